mips_dmem_responder: RTL and testbench

Data-memory responder for the pipelined MIPS CPU: the memory-side end of the CPU's load/store request/response interface. It accepts one request at a time over a valid/ready handshake, applies a fixed access latency, performs a byte-enabled word write or a word read on an internal array, and returns a response over a second valid/ready handshake. It sits between the CPU's MEM stage and the testbench/top level, and stalls the pipeline through back-pressure on `req_ready`.

---
 rtl/mips_dmem_responder_if.sv | 29 ++
 rtl/mips_dmem_responder.sv | 165 ++++++++++++++++
 tb/tb_mips_dmem_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mips_dmem_responder_if.sv
// ----------------------------------------------------------------------------
// mips_dmem_responder_if
// Request/response bus between the CPU MEM stage (master) and the data-memory
// responder (slave). Two independent valid/ready handshakes:
//   req_*  : CPU -> memory. we=1 store, addr is a byte address, be/wdata for stores.
//   rsp_*  : memory -> CPU. rdata is load data (0 for stores), err flags a bad access.
// ----------------------------------------------------------------------------
interface mips_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mips_dmem_responder.sv
// ----------------------------------------------------------------------------
// mips_dmem_responder
// Memory-side end of the CPU load/store interface. Accepts one request at a
// time, waits LATENCY cycles, performs a byte-enabled word store or a word
// load on an internal array, then presents the response until the CPU takes it.
//
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 2)
//   LATENCY     : wait cycles between acceptance and response (0..15)
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mips_dmem_responder_if.slave (req_* in, req_ready out, rsp_* out, rsp_ready in)
//
// Optional feature, macro DMEM_MISALIGN_CHECK_EN:
//   defined   -> accesses with addr[1:0] != 0 respond with rsp_err=1, rdata=0, no write
//   undefined -> addr[1:0] ignored, rsp_err tied 0
// The memory array is deliberately not reset.
// ----------------------------------------------------------------------------
module mips_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input logic                  clk,
    input logic                  rst,
    mips_dmem_responder_if.slave bus
);
    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LatCnt = 4'(LATENCY);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;
    logic            mis_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_err_q;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            accept;
    logic            req_mis;
    logic            acc_go;
    logic            acc_we;
    logic [AW-1:0]   acc_idx;
    logic [3:0]      acc_be;
    logic [31:0]     acc_wdata;
    logic            acc_mis;
    logic            mem_we;
    logic [31:0]     acc_rdata;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign req_mis = |bus.req_addr[1:0];
`else
    assign req_mis = 1'b0;
`endif

    // Upper address bits wrap; byte-offset bits only matter with the misalign check.
    logic unused_addr;
    assign unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};

    assign bus.req_ready = (state_q == StIdle) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    // Access operands: straight from the bus when LATENCY=0 (access on the
    // accept edge), otherwise from the latched request.
    always_comb begin
        acc_go    = 1'b0;
        acc_we    = we_q;
        acc_idx   = idx_q;
        acc_be    = be_q;
        acc_wdata = wdata_q;
        acc_mis   = mis_q;
        if (state_q == StIdle) begin
            acc_go    = accept && (LATENCY == 0);
            acc_we    = bus.req_we;
            acc_idx   = bus.req_addr[AW+1:2];
            acc_be    = bus.req_be;
            acc_wdata = bus.req_wdata;
            acc_mis   = req_mis;
        end else if (state_q == StWait) begin
            acc_go = (cnt_q == 4'd1);
        end
    end

    // Reset wins over a pending commit: a store still waiting is dropped.
    assign mem_we    = acc_go && acc_we && !acc_mis && !rst;
    assign acc_rdata = (acc_we || acc_mis) ? 32'h0 : mem_q[acc_idx];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            mis_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        we_q    <= bus.req_we;
                        idx_q   <= bus.req_addr[AW+1:2];
                        be_q    <= bus.req_be;
                        wdata_q <= bus.req_wdata;
                        mis_q   <= req_mis;
                        if (LATENCY == 0) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= acc_rdata;
                            rsp_err_q   <= acc_mis;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= LatCnt;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd1) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= acc_rdata;
                        rsp_err_q   <= acc_mis;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    // rdata/err stay as-is after the handshake; only valid drops.
                    if (bus.rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_mips_dmem_responder
// Directed bench for mips_dmem_responder with DEPTH_WORDS=256, LATENCY=2.
// Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_mips_dmem_responder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mips_dmem_responder_if bus ();

    mips_dmem_responder #(
        .DEPTH_WORDS(256),
        .LATENCY    (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One full transaction; hold = cycles rsp_ready stays low once rsp_valid is seen.
    task automatic transact(input string tag, input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input int hold);
        int n;
        @(negedge clk);
        check({tag, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_be    = be;
        bus.req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            check({tag, " req_ready busy"}, 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd3);
        if (bus.rsp_valid !== 1'b1) return;
        check({tag, " rdata"}, bus.rsp_rdata, exp_rdata);
        check({tag, " err"}, 32'(bus.rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, " hold rdata"}, bus.rsp_rdata, exp_rdata);
            check({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, " valid drop"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " req_ready back"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_be    = 4'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst req_ready", 32'(bus.req_ready), 32'd0);
        check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst rsp_err", 32'(bus.rsp_err), 32'd0);
        rst = 1'b0;
        #1;
        check("post-rst req_ready", 32'(bus.req_ready), 32'd1);

        // Store, load, partial store, load
        transact("st DEADBEEF", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        transact("ld 0x10 a", 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        transact("st byte0", 1'b1, 32'h10, 4'h1, 32'h000000AA, 32'h0, 1'b0, 0);
        transact("ld 0x10 b", 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEAA, 1'b0, 0);

        // be=0 store is a no-op that still responds
        transact("st be0", 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 0);
        transact("ld 0x10 c", 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEAA, 1'b0, 0);

        // Back-pressure on a load
        transact("bp ld", 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEAA, 1'b0, 5);

        // Address wrap
        transact("st wrap", 1'b1, 32'h400, 4'hF, 32'h12345678, 32'h0, 1'b0, 0);
        transact("ld wrap", 1'b0, 32'h0, 4'h0, 32'h0, 32'h12345678, 1'b0, 0);

        // Reset while a store waits: store must be dropped
        transact("st 0x20 init", 1'b1, 32'h20, 4'hF, 32'h11111111, 32'h0, 1'b0, 0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_be    = 4'hF;
        bus.req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        check("midrst valid a", 32'(bus.rsp_valid), 32'd0);
        check("midrst req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("midrst valid b", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst ready after", 32'(bus.req_ready), 32'd1);
        check("midrst valid after", 32'(bus.rsp_valid), 32'd0);
        transact("ld 0x20 dropped", 1'b0, 32'h20, 4'h0, 32'h0, 32'h11111111, 1'b0, 0);

        // Misaligned accesses
        transact("st 0x20 base", 1'b1, 32'h20, 4'hF, 32'h55555555, 32'h0, 1'b0, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
        transact("st mis", 1'b1, 32'h22, 4'hF, 32'hAABBCCDD, 32'h0, 1'b1, 0);
        transact("ld 0x20 mis", 1'b0, 32'h20, 4'h0, 32'h0, 32'h55555555, 1'b0, 0);
        transact("ld mis", 1'b0, 32'h21, 4'h0, 32'h0, 32'h0, 1'b1, 0);
`else
        transact("st mis", 1'b1, 32'h22, 4'hF, 32'hAABBCCDD, 32'h0, 1'b0, 0);
        transact("ld 0x20 mis", 1'b0, 32'h20, 4'h0, 32'h0, 32'hAABBCCDD, 1'b0, 0);
        transact("ld mis", 1'b0, 32'h21, 4'h0, 32'h0, 32'hAABBCCDD, 1'b0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
